// File: rtl/pedal_sensor_cond.sv
// Pedal sensor conditioning: synchronises the pedal pulse, counts cadence per window and averages torque.
// Define PEDAL_FAST_SIM_EN to shrink the cadence window to 4096 clks for simulation; leave undefined for synthesis.
module pedal_sensor_cond #(
  parameter int CAD_WIN_W = 24,
  parameter int TQ_SHIFT  = 5,
  parameter int NP_THRESH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cadence_raw,
  input  logic [11:0] torque,
  output logic [11:0] avg_torque,
  output logic [4:0]  cadence,
  output logic        not_pedaling
);

`ifdef PEDAL_FAST_SIM_EN
  localparam int WIN_W = 12;
`else
  localparam int WIN_W = CAD_WIN_W;
`endif
  localparam int ACC_W = 12 + TQ_SHIFT;
  localparam logic [4:0] NP_THRESH_C = 5'(NP_THRESH);

  typedef enum logic {
    PED_IDLE   = 1'b0,
    PED_ACTIVE = 1'b1
  } ped_state_e;

  logic             sync1_q, sync2_q, hist_q;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [4:0]       edge_cnt_q, edge_cnt_d;
  logic [4:0]       cadence_q, cadence_d;
  logic [ACC_W-1:0] accum_q, accum_d;
  logic             not_pedaling_q, not_pedaling_d;
  ped_state_e       state_q, state_d;

  logic       cad_rise;
  logic       win_wrap;
  logic       seed;
  logic [4:0] edge_inc;

  assign cad_rise = sync2_q & ~hist_q;
  assign win_wrap = &win_cnt_q;
  assign edge_inc = (edge_cnt_q == 5'd31) ? 5'd31 : edge_cnt_q + 5'd1;

  // Synchroniser and history flops; only rising edges of the pedal pulse matter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= cadence_raw;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  // A rise on the wrap cycle is counted in the closing window and seeds the new one.
  always_comb begin
    win_cnt_d  = win_cnt_q + WIN_W'(1);
    edge_cnt_d = edge_cnt_q;
    cadence_d  = cadence_q;
    if (win_wrap) begin
      cadence_d  = cad_rise ? edge_inc : edge_cnt_q;
      edge_cnt_d = {4'd0, cad_rise};
    end else if (cad_rise) begin
      edge_cnt_d = edge_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt_q  <= '0;
      edge_cnt_q <= '0;
      cadence_q  <= '0;
    end else begin
      win_cnt_q  <= win_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      cadence_q  <= cadence_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PED_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: decided only at window wrap, from the freshly latched cadence.
  always_comb begin
    state_d = state_q;
    if (win_wrap) begin
      state_d = (cadence_d >= NP_THRESH_C) ? PED_ACTIVE : PED_IDLE;
    end
  end

  // FSM outputs.
  always_comb begin
    not_pedaling_d = (state_d == PED_IDLE);
    seed           = (state_q == PED_IDLE) && (state_d == PED_ACTIVE);
  end

  // Seeding on entry avoids a slow ramp from a stale average; seeding beats a coincident update.
  always_comb begin
    accum_d = accum_q;
    if (seed) begin
      accum_d = {torque, {TQ_SHIFT{1'b0}}};
    end else if ((state_q == PED_ACTIVE) && cad_rise) begin
      accum_d = accum_q - (accum_q >> TQ_SHIFT) + ACC_W'(torque);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accum_q        <= '0;
      not_pedaling_q <= 1'b1;
    end else begin
      accum_q        <= accum_d;
      not_pedaling_q <= not_pedaling_d;
    end
  end

  assign avg_torque   = accum_q[TQ_SHIFT +: 12];
  assign cadence      = cadence_q;
  assign not_pedaling = not_pedaling_q;

endmodule

// File: tb/tb_pedal_sensor_cond.sv
// Bench for pedal_sensor_cond with a 4096-clk cadence window: vector table, corner sequences, random windows.
module tb_pedal_sensor_cond;

  localparam int WIN = 4096;

  logic        clk;
  logic        rst_n;
  logic        cadence_raw;
  logic [11:0] torque;
  logic [11:0] avg_torque;
  logic [4:0]  cadence;
  logic        not_pedaling;

  pedal_sensor_cond #(.CAD_WIN_W(12)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cadence_raw  (cadence_raw),
    .torque       (torque),
    .avg_torque   (avg_torque),
    .cadence      (cadence),
    .not_pedaling (not_pedaling)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: clocks counted since reset release, window closes every WIN clocks;
  // cadence = rises in the closed window (plus one carried from a rise on the previous close).
  int cyc = 0;
  int rise_q[$];
  int exp_q[$];
  int m_win = 0;
  int m_acc = 0;
  int m_cad = 0;
  bit m_active = 0;
  bit m_event = 0;

  task automatic model_step();
    bit rise;
    bit wrap;
    int c;
    if (!rst_n) begin
      cyc = 0; m_win = 0; m_acc = 0; m_cad = 0; m_active = 0; m_event = 0;
      rise_q.delete();
    end else begin
      cyc++;
      rise = (rise_q.size() > 0) && (rise_q[0] == cyc);
      if (rise) void'(rise_q.pop_front());
      wrap = (cyc % WIN) == 0;
      if (rise) m_win++;
      if (rise && m_active) m_acc = m_acc - m_acc / 32 + int'(torque);
      if (wrap) begin
        c = (m_win > 31) ? 31 : m_win;
        if (!m_active && c >= 2) m_acc = int'(torque) * 32;
        m_active = (c >= 2);
        m_cad = c;
        m_win = rise ? 1 : 0;
      end
      m_event = rise || wrap;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  // Scoreboard: on every model event, expected values are queued and compared at the negedge.
  initial forever begin
    @(negedge clk);
    if (rst_n && m_event) begin
      exp_q.push_back(m_cad);
      exp_q.push_back(int'(!m_active));
      exp_q.push_back((m_acc >> 5) & 'hFFF);
      chk("model_cadence", int'(cadence), exp_q.pop_front());
      chk("model_not_pedaling", int'(not_pedaling), exp_q.pop_front());
      chk("model_avg_torque", int'(avg_torque), exp_q.pop_front());
    end
  end

  // Driver tasks
  function automatic logic lvl(input int j, input int period, input int oa, input int ob);
    lvl = (period > 0 && (j % period) < period / 2) ||
          (oa >= 0 && j >= oa && j < oa + 2) ||
          (ob >= 0 && j >= ob && j < ob + 2);
  endfunction

  task automatic drive_cycle(input logic level);
    if (level && !cadence_raw) rise_q.push_back(cyc + 3);
    cadence_raw = level;
    @(posedge clk);
    #1;
  endtask

  task automatic run_window(input logic [11:0] tq, input int period, input int oa, input int ob);
    torque = tq;
    for (int j = 0; j < WIN; j++) drive_cycle(lvl(j, period, oa, ob));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    cadence_raw = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("reset_avg_torque", int'(avg_torque), 0);
    chk("reset_cadence", int'(cadence), 0);
    chk("reset_not_pedaling", int'(not_pedaling), 1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic chk_out(input string tag, input int e_cad, input int e_np, input int e_avg);
    chk({tag, "_cadence"}, int'(cadence), e_cad);
    chk({tag, "_not_pedaling"}, int'(not_pedaling), e_np);
    chk({tag, "_avg_torque"}, int'(avg_torque), e_avg);
  endtask

  typedef struct {
    logic [11:0] tq;
    int          period;
    int          exp_cad;
    int          exp_np;
    int          exp_avg;
  } vec_t;

  vec_t vecs[8];

  task automatic apply_row(input int i);
    run_window(vecs[i].tq, vecs[i].period, -1, -1);
    chk_out($sformatf("row%0d", i), vecs[i].exp_cad, vecs[i].exp_np, vecs[i].exp_avg);
  endtask

  initial begin
    int period;
    int oa;
    int ob;
    rst_n = 1'b0;
    cadence_raw = 1'b0;
    torque = '0;

    vecs[0] = '{12'h800, 0,    0,  1, 'h000};  // no edges after reset
    vecs[1] = '{12'h800, 256,  16, 0, 'h800};  // 16 edges: activate and seed
    vecs[2] = '{12'h800, 256,  16, 0, 'h800};
    vecs[3] = '{12'h800, 64,   31, 0, 'h800};  // 64 edges saturate
    vecs[4] = '{12'h100, 4096, 1,  1, 'h74D};  // last active update, then idle
    vecs[5] = '{12'h900, 4096, 1,  1, 'h74D};  // idle: average frozen
    vecs[6] = '{12'h300, 0,    0,  1, 'h74D};
    vecs[7] = '{12'h300, 128,  31, 0, 'h300};  // reactivate with fresh seed

    do_reset();
    for (int i = 0; i < 4; i++) apply_row(i);

    // Torque stepped to zero while active from a 0x800 seed.
    torque = 12'h000;
    for (int j = 0; j < WIN; j++) begin
      drive_cycle(lvl(j, 0, 0, 10));
      if (j == 5)  chk("step_first_rise", int'(avg_torque), 'h7C0);
      if (j == 15) chk("step_second_rise", int'(avg_torque), 'h782);
    end
    chk_out("step_wrap", 2, 0, 'h782);

    for (int i = 4; i < 8; i++) apply_row(i);

    // Reset in the middle of a pedaling window.
    for (int j = 0; j < 100; j++) drive_cycle(lvl(j, 64, -1, -1));
    do_reset();
    run_window(12'h800, 0, -1, -1);
    chk_out("post_reset_wrap", 0, 1, 'h000);

    // Rise coincident with the wrap while idle: counted twice, and seeding applies.
    run_window(12'h555, 0, 10, WIN - 3);
    chk_out("wrap_rise", 2, 0, 'h555);
    run_window(12'h555, 0, -1, -1);
    chk_out("wrap_carry", 1, 1, 'h555);

    // Random windows checked against the model.
    for (int w = 0; w < 3; w++) begin
      period = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(30, 1500));
      oa = int'($urandom_range(0, 4000));
      ob = int'($urandom_range(WIN - 8, WIN - 1));
      torque = 12'($urandom_range(0, 4095));
      for (int j = 0; j < WIN; j++) begin
        if ($urandom_range(0, 499) == 0) torque = 12'($urandom_range(0, 4095));
        drive_cycle(lvl(j, period, oa, ob));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
